// File: rtl/shift_deserializer_if.sv
// Bundle of the serial-input, parallel-output and status signals of shift_deserializer.
// Word handshake: a word transfers on every rising clk edge where data_valid && data_ready; data_out holds steady while data_valid=1.
interface shift_deserializer_if #(
  parameter int WIDTH = 8
);
  logic             s_in;
  logic             s_valid;
  logic             frame_start;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             data_ready;
  logic             busy;
  logic             frame_err;
  logic             overrun;
  logic             clr_overrun;

  modport master (
    output s_in, s_valid, frame_start, data_ready, clr_overrun,
    input  data_out, data_valid, busy, frame_err, overrun
  );

  modport slave (
    input  s_in, s_valid, frame_start, data_ready, clr_overrun,
    output data_out, data_valid, busy, frame_err, overrun
  );
endinterface

// File: rtl/shift_deserializer.sv
// Framed serial-to-parallel receiver with a single-entry valid/ready output buffer.
// Aborted frames pulse frame_err; words completed while the buffer is full set sticky overrun.
module shift_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  shift_deserializer_if.slave  bus,
  output logic                 o_dbg_state
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [WIDTH-1:0] w_first, w_shifted;
  logic [WIDTH-1:0] r_data;
  logic             r_valid, r_ferr, r_ovr;
  logic             w_done, w_abort, w_hs, w_drop;

  // A fresh frame clears stale partial bits so the word never depends on earlier aborts.
  generate
    if (MSB_FIRST) begin : g_msb
      assign w_first   = WIDTH'(bus.s_in);
      assign w_shifted = (r_shift << 1) | WIDTH'(bus.s_in);
    end else begin : g_lsb
      assign w_first   = WIDTH'(bus.s_in) << (WIDTH - 1);
      assign w_shifted = (r_shift >> 1) | (WIDTH'(bus.s_in) << (WIDTH - 1));
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.s_valid && bus.frame_start) begin
          w_shift_nxt = w_first;
          w_cnt_nxt   = CW'(1);
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.s_valid) begin
          if (bus.frame_start) begin
            w_abort     = 1'b1;
            w_shift_nxt = w_first;
            w_cnt_nxt   = CW'(1);
          end else begin
            w_shift_nxt = w_shifted;
            if (r_cnt == LAST_IDX) begin
              w_done      = 1'b1;
              w_cnt_nxt   = '0;
              w_state_nxt = IDLE;
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_hs   = r_valid & bus.data_ready;
  assign w_drop = w_done & r_valid & ~bus.data_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // A completion that coincides with a handshake reloads the buffer with no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= w_abort;
      if (w_done && !w_drop) begin
        r_data  <= w_shift_nxt;
        r_valid <= 1'b1;
      end else if (w_hs) begin
        r_valid <= 1'b0;
      end
      if (w_drop) begin
        r_ovr <= 1'b1;
      end else if (bus.clr_overrun) begin
        r_ovr <= 1'b0;
      end
    end
  end

  assign bus.data_out   = r_data;
  assign bus.data_valid = r_valid;
  assign bus.busy       = (r_state == SHIFT);
  assign bus.frame_err  = r_ferr;
  assign bus.overrun    = r_ovr;
  assign o_dbg_state    = (r_state == SHIFT);
endmodule

// File: doc/shift_deserializer.md
Name: shift_deserializer

Overview:
Serial-in, parallel-out receiver for the bit stream driven out of our shift-register chain's S_out end. It collects framed serial bits into WIDTH-bit words and presents each word on a single-entry, valid/ready-buffered parallel output. It sits at the far end of the shift chain and feeds downstream word-level logic.

Parameters:
WIDTH, 8, word length in bits (>= 2)
MSB_FIRST, 1, 1: first received bit lands in data_out[WIDTH-1]; 0: first bit lands in data_out[0]

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
s_in  input  1  serial data bit, sampled only when s_valid=1
s_valid  input  1  bit strobe; one bit accepted per clk edge where s_valid=1
frame_start  input  1  qualifies the current s_valid bit as bit 0 of a new word; ignored when s_valid=0
data_out  output  WIDTH  assembled word; stable while data_valid=1
data_valid  output  1  word available
data_ready  input  1  consumer accepts word when data_valid=1 and data_ready=1
busy  output  1  1 while in SHIFT state (partial word held)
frame_err  output  1  one-cycle pulse: word aborted by a premature frame_start
overrun  output  1  sticky: completed word dropped because buffer was full
clr_overrun  input  1  clears overrun (synchronous)

Behaviour:
- One clock (clk); reset is synchronous, active-high (rst). Every flop changes only on the rising edge of clk.
- Reset values: data_out=0, data_valid=0, busy=0, frame_err=0, overrun=0, bit counter=0, shift register=0, state=IDLE. rst overrides all other inputs, including a mid-word reset; the partial word is discarded with no error flag.
- FSM states: IDLE, SHIFT.
- IDLE: s_valid=1 with frame_start=1 -> store s_in as bit 0, count=1, go SHIFT. s_valid=1 with frame_start=0 -> bit discarded, stay IDLE, no flag.
- SHIFT: each s_valid=1 edge with frame_start=0 stores one bit and increments count. The edge that stores bit WIDTH-1 completes the word and returns to IDLE.
- SHIFT with s_valid=1 and frame_start=1: abort the partial word and pulse frame_err=1 on the next cycle. The new bit becomes bit 0 and count=1; stay SHIFT.
- s_valid=0 cycles (gaps) are allowed anywhere; state and count hold.
- Bit order: MSB_FIRST=1 shifts left, so the first bit ends at [WIDTH-1]. MSB_FIRST=0 shifts right, so the first bit ends at [0].
- Latency: data_out/data_valid update on the same edge that samples the last bit. data_valid is visible in the cycle following that edge.
- Output buffer (single entry):
  - data_valid=1 holds until a handshake (data_valid & data_ready) occurs; data_out is unchanged while held.
  - Handshake with no completion: data_valid -> 0.
  - Completion while data_valid=0: load word, data_valid -> 1.
  - Completion in the same cycle as a handshake: load the new word, data_valid stays 1 (no bubble).
  - Completion while data_valid=1 and data_ready=0: new word dropped, old word retained, overrun -> 1.
- overrun is sticky until clr_overrun=1 or rst. If clr_overrun and a new overrun event fall in the same cycle, set wins.
- busy = (state == SHIFT).
- Bit counter width is clog2(WIDTH+1). No wrap occurs because completion always returns to IDLE.

Test Plan:
- WIDTH=8, MSB_FIRST=1: frame_start on first bit, bits 1,0,1,0,0,1,0,1 on consecutive cycles, data_ready=1 -> data_out=0xA5, one-cycle data_valid pulse 1 cycle after last bit, busy high for bits 1..7.
- Same 0xA5 stream with 1–3 s_valid=0 gap cycles between bits -> identical data_out=0xA5; the stray s_valid bit in IDLE without frame_start is ignored.
- MSB_FIRST=0: bits 1,0,1,0,0,1,0,1 -> data_out=0xA5 bit-reversed = 0xA5 (palindrome check), then stream 1,1,0,0,0,0,0,0 -> data_out=0x03.
- data_ready=0: send 0x3C then 0xFF -> data_out stays 0x3C, data_valid=1, overrun=1. Raise data_ready -> handshake, data_valid=0. Pulse clr_overrun -> overrun=0. Back-to-back words with data_ready=1 on the completion edge -> data_valid never drops.
- Send 4 bits of a word, then frame_start with bits 0x81 -> frame_err pulses one cycle, output=0x81 only.
- Assert rst after 5 bits -> all outputs 0, state IDLE. The next full frame 0x5A is received correctly with frame_err=0.
